// File: rtl/coder_prio_seq_if.sv
// coder_prio_seq_if
// Request/result bundle for the priority encoder.
//   inp   : request word, active-low (bit = 0 means requesting)
//   ivld  : inp valid
//   irdy  : encoder can accept inp
//   res   : index of the selected zero bit
//   none  : accepted word had no zero bit
//   ovld  : res/none valid
//   ordy  : consumer accepts res
// Modports:
//   slave  : encoder side (takes requests, produces results)
//   master : environment side (drives requests, consumes results)
interface coder_prio_seq_if #(
    parameter int LW = 4
) ();
    localparam int W = 2 ** LW;

    logic [W-1:0]  inp;
    logic          ivld;
    logic          irdy;
    logic [LW-1:0] res;
    logic          none;
    logic          ovld;
    logic          ordy;

    modport slave (
        input  inp, ivld, ordy,
        output irdy, res, none, ovld
    );

    modport master (
        output inp, ivld, ordy,
        input  irdy, res, none, ovld
    );
endinterface

// File: rtl/coder_prio_seq.sv
// coder_prio_seq
// Registered first-zero priority encoder with valid/ready handshake on both
// sides and one cycle of latency. Finds the lowest-index zero bit of an
// active-low request word of 2**LW bits, scanning from bit 0 (fixed priority)
// or from a rotating pointer (round-robin).
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous, active-high reset
//   mode_i  : 0 = fixed priority, 1 = round-robin (sampled with the accepted word)
//   bus     : coder_prio_seq_if.slave (inp/ivld/irdy in, res/none/ovld/ordy out)
//   cnt_o   : count of accepted words that had a zero bit, saturating
//             (present only when CODER_PRIO_SEQ_STAT_EN is defined)
//
// Optional feature macro: CODER_PRIO_SEQ_STAT_EN
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no result held, ovld = 0
// ST_FULL  | result held in res_q/none_q, ovld = 1
module coder_prio_seq #(
    parameter int LW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode_i,
    coder_prio_seq_if.slave bus
`ifdef CODER_PRIO_SEQ_STAT_EN
    ,
    output logic [15:0]    cnt_o
`endif
);
    localparam int W = 2 ** LW;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] res_q, res_d;
    logic          none_q, none_d;
    logic [LW-1:0] ptr_q, ptr_d;

    logic          irdy;
    logic          accept;
    logic [LW-1:0] start;
    logic [LW-1:0] cand;
    logic          hit;
    logic [LW-1:0] hit_idx;

    assign irdy   = (state_q == ST_EMPTY) || bus.ordy;
    assign accept = bus.ivld && irdy;

    // Circular scan from the effective start; LW-bit addition wraps the
    // candidate index naturally, so every index is in range.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        cand    = '0;
        start   = mode_i ? ptr_q : '0;
        for (int i = 0; i < W; i++) begin
            cand = start + LW'(i);
            if (!hit && !bus.inp[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        none_d  = none_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!accept && bus.ordy) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept) begin
            // No zero bit reports the all-ones index, as the legacy encoder did.
            res_d  = hit ? hit_idx : '1;
            none_d = !hit;
            if (!mode_i) begin
                ptr_d = '0;
            end else if (hit) begin
                ptr_d = hit_idx + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            res_q   <= '0;
            none_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            none_q  <= none_d;
            ptr_q   <= ptr_d;
        end
    end

    // res/none are zeroed by reset, so they read 0 whenever reset is applied.
    assign bus.irdy = irdy;
    assign bus.ovld = (state_q == ST_FULL);
    assign bus.res  = res_q;
    assign bus.none = none_q;

`ifdef CODER_PRIO_SEQ_STAT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && hit && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_coder_prio_seq.sv
module tb_coder_prio_seq;
    localparam int LW = 4;
    localparam int W  = 2 ** LW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;

    coder_prio_seq_if #(.LW(LW)) bus ();

`ifdef CODER_PRIO_SEQ_STAT_EN
    logic [15:0] cnt;
`endif

    coder_prio_seq #(.LW(LW)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode),
        .bus    (bus.slave)
`ifdef CODER_PRIO_SEQ_STAT_EN
        ,
        .cnt_o  (cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (transaction level).
    bit          m_ovld;
    int          m_res;
    bit          m_none;
    int          m_ptr;
    int          m_cnt;

    // Currently driven inputs.
    logic [W-1:0] d_inp;
    bit           d_ivld, d_mode, d_ordy;

    function automatic void model_reset();
        m_ovld = 0; m_res = 0; m_none = 0; m_ptr = 0; m_cnt = 0;
    endfunction

    // One rising edge of the reference behaviour: find the first requesting
    // position going round the word from the start point.
    function automatic void model_step();
        bit acc;
        int s;
        int found;
        acc = d_ivld && (!m_ovld || d_ordy);
        if (acc) begin
            s = d_mode ? m_ptr : 0;
            found = -1;
            for (int k = 0; k < W; k++) begin
                if (found < 0 && d_inp[(s + k) % W] == 1'b0) found = (s + k) % W;
            end
            m_ovld = 1;
            m_none = (found < 0);
            m_res  = (found < 0) ? W - 1 : found;
            if (!d_mode) m_ptr = 0;
            else if (found >= 0) m_ptr = (found + 1) % W;
            if (found >= 0 && m_cnt < 65535) m_cnt++;
        end else if (m_ovld && d_ordy) begin
            m_ovld = 0;
        end
    endfunction

    task automatic set_inputs(input logic [W-1:0] inp, input bit ivld, input bit md, input bit ordy);
        d_inp = inp; d_ivld = ivld; d_mode = md; d_ordy = ordy;
        bus.inp  = inp;
        bus.ivld = ivld;
        bus.ordy = ordy;
        mode     = md;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        set_inputs('1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.ovld !== 1'b0 || bus.res !== 4'h0 || bus.none !== 1'b0)
            $display("FAIL reset_outputs: got ovld=%b res=%0h none=%b exp 0/0/0", bus.ovld, bus.res, bus.none);
        else n_pass++;
        n_checks++;
        if (bus.irdy !== 1'b1) $display("FAIL reset_irdy: got %b exp 1", bus.irdy);
        else n_pass++;
`ifdef CODER_PRIO_SEQ_STAT_EN
        n_checks++;
        if (cnt !== 16'h0) $display("FAIL reset_cnt: got %0h exp 0", cnt);
        else n_pass++;
`endif
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.ovld !== 1'b0) $display("FAIL idle_after_reset: got ovld=%b exp 0", bus.ovld);
        else n_pass++;
    endtask

    task automatic test_fixed();
        logic [W-1:0] words [3] = '{16'h7FFF, 16'h0000, 16'hFFF6};
        logic [LW-1:0] exp_res [3] = '{4'hF, 4'h0, 4'h0};
        for (int i = 0; i < 3; i++) begin
            set_inputs(words[i], 1'b1, 1'b0, 1'b1);
            tick();
            n_checks++;
            if (bus.ovld !== 1'b1 || bus.res !== exp_res[i] || bus.none !== 1'b0)
                $display("FAIL fixed_%0d: got ovld=%b res=%0h none=%b exp 1/%0h/0", i, bus.ovld, bus.res, bus.none, exp_res[i]);
            else n_pass++;
        end
        set_inputs('1, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (bus.ovld !== 1'b0) $display("FAIL fixed_drain: got ovld=%b exp 0", bus.ovld);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] exp_res [3] = '{4'h0, 4'h3, 4'h0};
        for (int i = 0; i < 3; i++) begin
            set_inputs(16'hFFF6, 1'b1, 1'b1, 1'b1);
            tick();
            n_checks++;
            if (bus.ovld !== 1'b1 || bus.res !== exp_res[i])
                $display("FAIL rr_wrap_%0d: got ovld=%b res=%0h exp 1/%0h", i, bus.ovld, bus.res, exp_res[i]);
            else n_pass++;
        end
        // PTR should now be 1: an all-requesting word reveals it directly.
        set_inputs(16'h0000, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.ovld !== 1'b1 || bus.res !== 4'h1)
            $display("FAIL rr_ptr_probe: got ovld=%b res=%0h exp 1/1", bus.ovld, bus.res);
        else n_pass++;
    endtask

    task automatic test_all_ones();
        int cnt_before;
        set_inputs(16'hFFEF, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.res !== 4'h4) $display("FAIL ones_setup: got res=%0h exp 4", bus.res);
        else n_pass++;
        cnt_before = m_cnt;
        set_inputs(16'hFFFF, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.ovld !== 1'b1 || bus.none !== 1'b1 || bus.res !== 4'hF)
            $display("FAIL ones_result: got ovld=%b none=%b res=%0h exp 1/1/f", bus.ovld, bus.none, bus.res);
        else n_pass++;
`ifdef CODER_PRIO_SEQ_STAT_EN
        n_checks++;
        if (cnt !== 16'(cnt_before)) $display("FAIL ones_cnt: got %0h exp %0h", cnt, cnt_before);
        else n_pass++;
`endif
        set_inputs(16'h0000, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.res !== 4'h5 || bus.none !== 1'b0)
            $display("FAIL ones_ptr_kept: got res=%0h none=%b exp 5/0", bus.res, bus.none);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        set_inputs(16'hFFF7, 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_inputs(16'($urandom), 1'b1, 1'($urandom), 1'b0);
            n_checks++;
            if (bus.irdy !== 1'b0) $display("FAIL stall_irdy_%0d: got %b exp 0", i, bus.irdy);
            else n_pass++;
            tick();
            n_checks++;
            if (bus.ovld !== 1'b1 || bus.res !== 4'h3 || bus.none !== 1'b0)
                $display("FAIL stall_hold_%0d: got ovld=%b res=%0h none=%b exp 1/3/0", i, bus.ovld, bus.res, bus.none);
            else n_pass++;
        end
        set_inputs(16'hFFDF, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (bus.irdy !== 1'b1) $display("FAIL release_irdy: got %b exp 1", bus.irdy);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.ovld !== 1'b1 || bus.res !== 4'h5)
            $display("FAIL release_next: got ovld=%b res=%0h exp 1/5", bus.ovld, bus.res);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        set_inputs(16'hFF7F, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.res !== 4'h7 || bus.ovld !== 1'b1)
            $display("FAIL areset_setup: got res=%0h ovld=%b exp 7/1", bus.res, bus.ovld);
        else n_pass++;
        set_inputs('1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.ovld !== 1'b0 || bus.res !== 4'h0 || bus.none !== 1'b0)
            $display("FAIL areset_immediate: got ovld=%b res=%0h none=%b exp 0/0/0", bus.ovld, bus.res, bus.none);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_inputs(16'h0000, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.res !== 4'h0) $display("FAIL areset_ptr_zero: got res=%0h exp 0", bus.res);
        else n_pass++;
        model_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        set_inputs(16'hFF7F, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.res !== 4'h7 || bus.ovld !== 1'b1)
            $display("FAIL areset_restart: got res=%0h ovld=%b exp 7/1", bus.res, bus.ovld);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) w = '1;
            else w = 16'($urandom) | 16'($urandom);
            set_inputs(w, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            n_checks++;
            if (bus.irdy !== (!m_ovld || d_ordy))
                $display("FAIL rand_irdy_%0d: got %b exp %b", i, bus.irdy, (!m_ovld || d_ordy));
            else n_pass++;
            tick();
            n_checks++;
            if (bus.ovld !== m_ovld || bus.res !== LW'(m_res) || bus.none !== m_none)
                $display("FAIL rand_out_%0d: got ovld=%b res=%0h none=%b exp %b/%0h/%b",
                         i, bus.ovld, bus.res, bus.none, m_ovld, m_res, m_none);
            else n_pass++;
`ifdef CODER_PRIO_SEQ_STAT_EN
            n_checks++;
            if (cnt !== 16'(m_cnt)) $display("FAIL rand_cnt_%0d: got %0h exp %0h", i, cnt, m_cnt);
            else n_pass++;
`endif
        end
    endtask

`ifdef CODER_PRIO_SEQ_STAT_EN
    task automatic test_stat_sat();
        set_inputs(16'h0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 70000 && m_cnt < 16'hFFFE; i++) tick();
        n_checks++;
        if (cnt !== 16'hFFFE) $display("FAIL stat_preload: got %0h exp fffe", cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            set_inputs(16'hFFFE, 1'b1, 1'($urandom), 1'b1);
            tick();
            n_checks++;
            if (cnt !== 16'hFFFF) $display("FAIL stat_sat_%0d: got %0h exp ffff", i, cnt);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        d_inp = '1; d_ivld = 0; d_mode = 0; d_ordy = 0;
        bus.inp = '1; bus.ivld = 1'b0; bus.ordy = 1'b0;
        test_reset();
        test_fixed();
        test_back_to_back();
        test_all_ones();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef CODER_PRIO_SEQ_STAT_EN
        test_stat_sat();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
